nn_layer_sequencer: RTL and testbench

//  Control FSM upstream of the neural-network datapath. It sequences one classification

---
 rtl/nn_layer_sequencer.sv | 169 ++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// Sequencer for the NN datapath: runs layer1, layer2, output passes.
// Ports: clk, rst(active-low async), go, ready, class_in -> layer/handshake outputs, class_out, done, timeout_err.
module nn_layer_sequencer #(
    parameter int READY_MASK = 2,
    parameter int TIMEOUT    = 255,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       ready,
    input  logic [7:0] class_in,
    output logic [1:0] state,
    output logic       start,
    output logic       hidden,
    output logic       ld1,
    output logic       ld2,
    output logic       busy,
    output logic       done,
    output logic [7:0] class_out,
    output logic       timeout_err
);

    typedef enum logic [3:0] {
        IDLE, S1, W1, L1, S2, W2, L2, S3, W3, CAP
    } fsm_e;

    localparam logic [CW-1:0] MASK_C = CW'(READY_MASK);
    localparam logic [CW-1:0] TO_C   = CW'(TIMEOUT);

    fsm_e          fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    class_q, class_d;
    logic          terr_q, terr_d;
    logic [1:0]    state_q, state_d;
    logic          start_q, start_d;
    logic          hidden_q, hidden_d;
    logic          ld1_q, ld1_d;
    logic          ld2_q, ld2_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        terr_d = terr_q;
        unique case (fsm_q)
            IDLE: begin
                if (go) begin
                    fsm_d  = S1;
                    terr_d = 1'b0;
                end
            end
            S1: begin
                cnt_d = '0;
                fsm_d = W1;
            end
            S2: begin
                cnt_d = '0;
                fsm_d = W2;
            end
            S3: begin
                cnt_d = '0;
                fsm_d = W3;
            end
            W1, W2, W3: begin
                cnt_d = cnt_q + CW'(1);
                // ready is checked first so it wins over a coincident timeout
                if (cnt_q >= MASK_C && ready) begin
                    if (fsm_q == W1)
                        fsm_d = L1;
                    else if (fsm_q == W2)
                        fsm_d = L2;
                    else
                        fsm_d = CAP;
                end else if (cnt_q == TO_C) begin
                    fsm_d  = IDLE;
                    terr_d = 1'b1;
                end
            end
            L1:      fsm_d = S2;
            L2:      fsm_d = S3;
            CAP:     fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they
    // line up with the FSM state they describe.
    always_comb begin
        class_d  = class_q;
        state_d  = 2'b00;
        hidden_d = 1'b1;
        start_d  = 1'b0;
        ld1_d    = 1'b0;
        ld2_d    = 1'b0;
        done_d   = 1'b0;
        busy_d   = (fsm_d != IDLE);
        unique case (fsm_d)
            S1:      start_d = 1'b1;
            L1:      ld1_d   = 1'b1;
            S2: begin
                state_d = 2'b01;
                start_d = 1'b1;
            end
            W2:      state_d = 2'b01;
            L2: begin
                state_d = 2'b01;
                ld2_d   = 1'b1;
            end
            S3: begin
                state_d  = 2'b10;
                hidden_d = 1'b0;
                start_d  = 1'b1;
            end
            W3: begin
                state_d  = 2'b10;
                hidden_d = 1'b0;
            end
            CAP: begin
                state_d  = 2'b10;
                hidden_d = 1'b0;
                done_d   = 1'b1;
                // captured on entry so class_out changes with done
                class_d  = class_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q    <= IDLE;
            cnt_q    <= '0;
            class_q  <= 8'h00;
            terr_q   <= 1'b0;
            state_q  <= 2'b00;
            start_q  <= 1'b0;
            hidden_q <= 1'b1;
            ld1_q    <= 1'b0;
            ld2_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            class_q  <= class_d;
            terr_q   <= terr_d;
            state_q  <= state_d;
            start_q  <= start_d;
            hidden_q <= hidden_d;
            ld1_q    <= ld1_d;
            ld2_q    <= ld2_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign state       = state_q;
    assign start       = start_q;
    assign hidden      = hidden_q;
    assign ld1         = ld1_q;
    assign ld2         = ld2_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign class_out   = class_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer.
// Expected class results are queued at stimulus time and checked on done.
module tb_nn_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go = 1'b0;
    logic       ready;
    logic [7:0] class_in = 8'h00;
    logic [1:0] state;
    logic       start, hidden, ld1, ld2, busy, done, timeout_err;
    logic [7:0] class_out;

    nn_layer_sequencer dut (
        .clk(clk), .rst(rst), .go(go), .ready(ready),
        .class_in(class_in), .state(state), .start(start),
        .hidden(hidden), .ld1(ld1), .ld2(ld2), .busy(busy),
        .done(done), .class_out(class_out),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0] exp_q[$];
    int   st_log[$];
    int   hid_log[$];
    int   n_start = 0, n_ld1 = 0, n_ld2 = 0, n_done = 0;
    int   first_busy_cyc = 0, done_cyc = 0, last_start_cyc = 0;
    logic prev_busy = 1'b0, prev_done = 1'b0;

    int r_mode = 0;
    int r_dly = 3;
    int rcnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (start) begin
                n_start++;
                last_start_cyc = cyc;
                st_log.push_back(int'(state));
                hid_log.push_back(int'(hidden));
            end
            if (ld1) n_ld1++;
            if (ld2) n_ld2++;
            if (busy && !prev_busy) first_busy_cyc = cyc;
            if (prev_done) check("busy_after_done", busy, 0);
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_done: class_out %0h, none expected",
                             class_out);
                end else begin
                    check("class_out", class_out, exp_q.pop_front());
                end
            end
            prev_done = done;
            prev_busy = busy;
        end else begin
            prev_done = 1'b0;
            prev_busy = 1'b0;
        end
    end

    // ready model: 0 = rise r_dly cycles after each start,
    // 1 = always high, 2 = as 0 but held low from the layer-2 pass on
    initial begin
        ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (r_mode == 1) begin
                ready = 1'b1;
            end else if (!busy) begin
                ready = 1'b0;
                rcnt = 0;
            end else begin
                if (start) begin
                    rcnt = 0;
                    ready = 1'b0;
                end else begin
                    rcnt++;
                end
                if (r_mode == 2 && state == 2'b01)
                    ready = 1'b0;
                else if (!start && rcnt >= r_dly)
                    ready = 1'b1;
            end
        end
    end

    task automatic pulse_go();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int  d0;
        bit  ok;
        d0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk);
            if (n_done != d0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL %s: no done within %0d cycles", name, max);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_hidden"}, hidden, 1);
        check({tag, "_ld"}, {ld1, ld2}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_class"}, class_out, 8'h00);
        check({tag, "_terr"}, timeout_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, l2_0, dl;
        bit seen;

        // reset state
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: nominal run, ready 63 cycles after each start
        r_mode = 0;
        r_dly = 63;
        class_in = 8'h07;
        n_start = 0; n_ld1 = 0; n_ld2 = 0; n_done = 0;
        st_log.delete();
        hid_log.delete();
        exp_q.push_back(8'h07);
        pulse_go();
        wait_done("t1_done", 1000);
        repeat (3) @(negedge clk);
        check("t1_starts", n_start, 3);
        check("t1_ld1", n_ld1, 1);
        check("t1_ld2", n_ld2, 1);
        check("t1_dones", n_done, 1);
        if (st_log.size() == 3 && hid_log.size() == 3) begin
            check("t1_state0", st_log[0], 0);
            check("t1_state1", st_log[1], 1);
            check("t1_state2", st_log[2], 2);
            check("t1_hid0", hid_log[0], 1);
            check("t1_hid1", hid_log[1], 1);
            check("t1_hid2", hid_log[2], 0);
        end else begin
            check("t1_log_size", st_log.size(), 3);
        end
        check("t1_class_hold", class_out, 8'h07);
        check("t1_idle_state", state, 0);
        check("t1_idle_hidden", hidden, 1);

        // 2: ready stuck high, minimum latency
        r_mode = 1;
        class_in = 8'h5a;
        exp_q.push_back(8'h5a);
        pulse_go();
        wait_done("t2_done", 100);
        check("t2_latency", done_cyc - first_busy_cyc, 14);
        r_mode = 0;
        repeat (3) @(negedge clk);

        // 3: ready never comes in the layer-2 pass
        r_mode = 2;
        r_dly = 5;
        class_in = 8'h33;
        d0 = n_done;
        l2_0 = n_ld2;
        pulse_go();
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (timeout_err) begin
                seen = 1'b1;
                break;
            end
        end
        check("t3_terr_seen", seen, 1);
        dl = cyc - last_start_cyc;
        check("t3_latency_window", (dl >= 255 && dl <= 258), 1);
        @(negedge clk);
        check("t3_busy", busy, 0);
        check("t3_no_ld2", n_ld2 - l2_0, 0);
        check("t3_no_done", n_done - d0, 0);
        check("t3_class_kept", class_out, 8'h5a);
        check("t3_terr_sticky", timeout_err, 1);
        r_mode = 0;
        r_dly = 4;
        class_in = 8'h11;
        exp_q.push_back(8'h11);
        pulse_go();
        check("t3_terr_cleared", timeout_err, 0);
        wait_done("t3_done", 200);
        repeat (3) @(negedge clk);

        // 4: go held across a run, then once more in the idle cycle
        r_dly = 3;
        class_in = 8'h44;
        n_start = 0;
        n_done = 0;
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h45);
        @(negedge clk);
        go = 1'b1;
        wait_done("t4_done1", 200);
        check("t4_starts_one_run", n_start, 3);
        @(negedge clk);
        @(negedge clk);
        go = 1'b0;
        class_in = 8'h45;
        check("t4_restart_busy", busy, 1);
        wait_done("t4_done2", 200);
        repeat (5) @(negedge clk);
        check("t4_total_dones", n_done, 2);
        check("t4_total_starts", n_start, 6);

        // 5: reset pulse during the layer-2 wait
        r_dly = 40;
        class_in = 8'h66;
        d0 = n_done;
        l2_0 = n_ld1;
        pulse_go();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_ld1 != l2_0) break;
        end
        repeat (5) @(negedge clk);
        check("t5_in_w2", state, 2'b01);
        rst = 1'b0;
        #1;
        check_reset_vals("t5");
        @(negedge clk);
        rst = 1'b1;
        repeat (400) @(negedge clk);
        check("t5_no_done", n_done - d0, 0);
        check("t5_idle", busy, 0);

        // 6: back-to-back runs, class_out holds in between
        r_dly = 3;
        class_in = 8'h03;
        exp_q.push_back(8'h03);
        pulse_go();
        wait_done("t6_done1", 200);
        repeat (10) @(negedge clk);
        class_in = 8'h09;
        repeat (5) @(negedge clk);
        check("t6_hold", class_out, 8'h03);
        exp_q.push_back(8'h09);
        pulse_go();
        wait_done("t6_done2", 200);
        repeat (3) @(negedge clk);
        check("t6_final", class_out, 8'h09);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
